// File: rtl/led_pattern_seq.sv
// Test-pattern source for the LED driver: solid, split, chase and fade frames
// with a start/done handshake. Define LED_DIM_EN to add the 2-bit dim input.
module led_pattern_seq #(
  parameter int unsigned LEDS            = 50,
  parameter int unsigned FRAMES_PER_STEP = 2000,
  parameter int unsigned SEGMENTS        = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [1:0]           mode,
  input  logic                 done,
`ifdef LED_DIM_EN
  input  logic [1:0]           dim,
`endif
  output logic [24*LEDS-1:0]   led_rgb,
  output logic                 start,
  output logic [2:0]           step_idx
);

  localparam int unsigned FcW = $clog2(FRAMES_PER_STEP + 1);
  localparam int unsigned CpW = $clog2(LEDS + 1);

  typedef enum logic [1:0] {StInit, StStart, StWait, StUpdate} state_e;

  state_e         state_q;
  logic [1:0]     mode_q;
  logic           done_q;
  logic [FcW-1:0] frame_cnt;
  logic [CpW-1:0] chase_pos;
  logic [7:0]     fade_lvl;

  logic [1:0]     mode_d;
  logic [FcW-1:0] frame_d;
  logic [CpW-1:0] chase_d;
  logic [7:0]     fade_d;
  logic [2:0]     step_d;
  logic [1:0]     dim_w;
  logic [24*LEDS-1:0] rgb_d;

`ifdef LED_DIM_EN
  assign dim_w = dim;
`else
  assign dim_w = 2'd0;
`endif

  // Palette index bits map straight onto the R, G and B channels.
  function automatic logic [23:0] pal(input logic [2:0] s);
    return {{8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
  endfunction

  function automatic logic [7:0] scale(input logic [7:0] c, input logic [7:0] lvl);
    logic [15:0] prod;
    prod = 16'(c) * (16'(lvl) + 16'd1);
    return prod[15:8];
  endfunction

  function automatic logic [23:0] fade_px(input logic [23:0] c, input logic [7:0] lvl);
    return {scale(c[23:16], lvl), scale(c[15:8], lvl), scale(c[7:0], lvl)};
  endfunction

  function automatic logic [23:0] dim_px(input logic [23:0] c, input logic [1:0] d);
    return {c[23:16] >> d, c[15:8] >> d, c[7:0] >> d};
  endfunction

  // Bookkeeping as it would be applied by UPDATE; INIT only latches the mode.
  always_comb begin
    mode_d  = mode_q;
    frame_d = frame_cnt;
    step_d  = step_idx;
    chase_d = chase_pos;
    fade_d  = fade_lvl;
    if (state_q == StInit) begin
      mode_d = mode;
    end else if (mode != mode_q) begin
      mode_d  = mode;
      frame_d = '0;
      step_d  = '0;
      chase_d = '0;
      fade_d  = '0;
    end else if (frame_cnt == FcW'(FRAMES_PER_STEP - 1)) begin
      frame_d = '0;
      step_d  = step_idx + 3'd1;
      chase_d = (chase_pos == CpW'(LEDS - 1)) ? '0 : chase_pos + CpW'(1);
      fade_d  = '0;
    end else begin
      frame_d = frame_cnt + FcW'(1);
      fade_d  = (fade_lvl == 8'hff) ? 8'hff : fade_lvl + 8'd1;
    end
  end

  always_comb begin
    rgb_d = '0;
    for (int unsigned i = 0; i < LEDS; i++) begin
      int unsigned k;
      logic [23:0] px;
      k  = (i * SEGMENTS) / LEDS;
      px = '0;
      unique case (mode_d)
        2'd0:    px = pal(step_d);
        2'd1:    px = pal(step_d + 3'(k));
        2'd2:    px = (chase_d == CpW'(i)) ? 24'hffffff : 24'h000000;
        default: px = fade_px(pal(step_d), fade_d);
      endcase
      rgb_d[24*(LEDS-i)-1 -: 24] = dim_px(px, dim_w);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StInit;
      led_rgb   <= '0;
      start     <= 1'b0;
      step_idx  <= '0;
      frame_cnt <= '0;
      chase_pos <= '0;
      fade_lvl  <= '0;
      done_q    <= 1'b0;
      mode_q    <= '0;
    end else begin
      start <= 1'b0;
      unique case (state_q)
        StInit: begin
          mode_q  <= mode_d;
          led_rgb <= rgb_d;
          state_q <= StStart;
        end
        StStart: begin
          start   <= 1'b1;
          state_q <= StWait;
        end
        StWait: begin
          done_q <= done;
          if (done && !done_q) state_q <= StUpdate;
        end
        StUpdate: begin
          mode_q    <= mode_d;
          frame_cnt <= frame_d;
          step_idx  <= step_d;
          chase_pos <= chase_d;
          fade_lvl  <= fade_d;
          led_rgb   <= rgb_d;
          state_q   <= StStart;
        end
        default: state_q <= StInit;
      endcase
    end
  end

endmodule

// File: tb/tb_led_pattern_seq.sv
// Randomised bench for led_pattern_seq: two instances (3 and 300 frames per step)
// share the handshake and are checked against a frame-level reference model.
module tb_led_pattern_seq;

  localparam int NL  = 4;
  localparam int SEG = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            done = 1'b0;
  logic [1:0]      mode = 2'd0;
  logic [1:0]      dim = 2'd0;
  logic [24*NL-1:0] rgb_a, rgb_b;
  logic            start_a, start_b;
  logic [2:0]      step_a, step_b;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  led_pattern_seq #(.LEDS(NL), .FRAMES_PER_STEP(3), .SEGMENTS(SEG)) u_dut_a (
    .clk(clk), .rst(rst), .mode(mode), .done(done),
`ifdef LED_DIM_EN
    .dim(dim),
`endif
    .led_rgb(rgb_a), .start(start_a), .step_idx(step_a)
  );

  led_pattern_seq #(.LEDS(NL), .FRAMES_PER_STEP(300), .SEGMENTS(SEG)) u_dut_b (
    .clk(clk), .rst(rst), .mode(mode), .done(done),
`ifdef LED_DIM_EN
    .dim(dim),
`endif
    .led_rgb(rgb_b), .start(start_b), .step_idx(step_b)
  );

  logic [23:0] pal_tab [8] = '{24'h000000, 24'h0000ff, 24'h00ff00, 24'h00ffff,
                               24'hff0000, 24'hff00ff, 24'hffff00, 24'hffffff};
  int fps [2] = '{3, 300};
  int m_mode, m_dim;
  int m_frame [2];
  int m_step  [2];
  int m_chase [2];
  int m_fade  [2];

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int eff_dim(input int d);
`ifdef LED_DIM_EN
    return d;
`else
    return 0;
`endif
  endfunction

  function automatic logic [24*NL-1:0] model_frame(input int n);
    logic [24*NL-1:0] f;
    f = '0;
    for (int i = 0; i < NL; i++) begin
      logic [23:0] c;
      int seg;
      seg = (i * SEG) / NL;
      case (m_mode)
        0:       c = pal_tab[m_step[n]];
        1:       c = pal_tab[(m_step[n] + seg) % 8];
        2:       c = (i == m_chase[n]) ? 24'hffffff : 24'h000000;
        default: begin
          c = pal_tab[m_step[n]];
          for (int j = 0; j < 3; j++) begin
            int v;
            v = int'(c[8*j +: 8]) * (m_fade[n] + 1) / 256;
            c[8*j +: 8] = 8'(v);
          end
        end
      endcase
      for (int j = 0; j < 3; j++) c[8*j +: 8] = c[8*j +: 8] >> m_dim;
      f[24*(NL-1-i) +: 24] = c;
    end
    return f;
  endfunction

  task automatic model_reset();
    m_mode = int'(mode);
    m_dim  = eff_dim(int'(dim));
    for (int n = 0; n < 2; n++) begin
      m_frame[n] = 0; m_step[n] = 0; m_chase[n] = 0; m_fade[n] = 0;
    end
  endtask

  task automatic model_update(input int new_mode, input int new_dim);
    bit chg;
    chg = (new_mode != m_mode);
    for (int n = 0; n < 2; n++) begin
      if (chg) begin
        m_frame[n] = 0; m_step[n] = 0; m_chase[n] = 0; m_fade[n] = 0;
      end else if (m_frame[n] == fps[n] - 1) begin
        m_frame[n] = 0;
        m_step[n]  = (m_step[n] + 1) % 8;
        m_chase[n] = (m_chase[n] + 1) % NL;
        m_fade[n]  = 0;
      end else begin
        m_frame[n]++;
        m_fade[n] = (m_fade[n] + 1 > 255) ? 255 : m_fade[n] + 1;
      end
    end
    m_mode = new_mode;
    m_dim  = eff_dim(new_dim);
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "_rgb_a"}, rgb_a, model_frame(0));
    check({tag, "_rgb_b"}, rgb_b, model_frame(1));
    check({tag, "_step_a"}, step_a, m_step[0]);
    check({tag, "_step_b"}, step_b, m_step[1]);
  endtask

  // Asserts reset between edges, checks the immediate clear, then the startup frame.
  task automatic do_reset();
    int starts;
    #2 rst = 1'b1;
    done = 1'b0;
    #1;
    check("rst_rgb_a", rgb_a, '0);
    check("rst_rgb_b", rgb_b, '0);
    check("rst_start", {start_a, start_b}, 2'b00);
    check("rst_step", {step_a, step_b}, 6'd0);
    tick();
    tick();
    rst = 1'b0;
    model_reset();
    tick();
    check("init_start0", start_a, 1'b0);
    tick();
    check("init_start1", {start_a, start_b}, 2'b11);
    check_outputs("init");
    starts = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      starts += int'(start_a);
    end
    check("init_idle", starts, 0);
  endtask

  task automatic run_frame(input int new_mode, input int new_dim, input int hold);
    int idle, starts;
    mode = 2'(new_mode);
    dim  = 2'(new_dim);
    idle = $urandom_range(0, 3);
    starts = 0;
    for (int c = 0; c < idle; c++) begin
      tick();
      starts += int'(start_a);
    end
    check("idle_start", starts, 0);
    done = 1'b1;
    model_update(new_mode, new_dim);
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (c == hold) done = 1'b0;
      if (start_a || start_b) begin
        starts++;
        check("latency", c, 3);
        check("start_pair", {start_a, start_b}, 2'b11);
        check_outputs("frame");
      end
    end
    check("starts_per_done", starts, 1);
    check("stable_rgb_a", rgb_a, model_frame(0));
  endtask

  initial begin
    do_reset();
    for (int f = 0; f < 9; f++) run_frame(0, 0, (f == 4) ? 5 : 1);
    for (int f = 0; f < 24; f++) run_frame(1, 0, int'($urandom_range(1, 5)));
    for (int f = 0; f < 13; f++) run_frame(2, 0, int'($urandom_range(1, 5)));
    for (int f = 0; f < 60; f++) begin
      int md;
      md = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : m_mode;
      run_frame(md, int'($urandom_range(0, 3)), int'($urandom_range(1, 5)));
    end
    tick();
    do_reset();
    for (int f = 0; f < 310; f++) run_frame(3, 0, int'($urandom_range(1, 3)));
    for (int f = 0; f < 24; f++) run_frame(0, 0, 1);
    for (int f = 0; f < 3; f++) run_frame(3, 0, 1);
    run_frame(0, 0, 2);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
